// File: rtl/riscv_pkg.sv
// Shared core definitions: program-counter width and the program loader state encoding.
package riscv_pkg;

  localparam int PROGRAM_COUNTER_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into DATA_WIDTH-bit words and emits one
// registered word_valid pulse per completed word.
module word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic                  last_byte,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;

  // Newest byte enters at the top, so the first byte ends up in bits [7:0].
  assign shift_next = (shift >> 8) | (DATA_WIDTH'(byte_data) << (DATA_WIDTH - 8));
  assign last_byte  = (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (byte_en) begin
        shift <= shift_next;
        if (last_byte) begin
          idx        <= '0;
          word_valid <= 1'b1;
          word       <= shift_next;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, XOR-checksummed program byte stream, writes it to
// instruction memory word by word, and releases the core only on a good image.
module program_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = PROGRAM_COUNTER_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  run,
  output logic                  loading,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  loader_state_t state;
  logic [15:0]   len;
  logic [7:0]    xor_acc;
  logic          accept;
  logic          asm_clear;
  logic          asm_byte_en;
  logic          asm_last;

  assign byte_ready  = (state inside {LEN_LO, LEN_HI, DATA, CHECK});
  assign loading     = byte_ready;
  assign run         = (state == RUN);
  assign error       = (state == ERROR);
  assign accept      = byte_valid && byte_ready;
  assign asm_clear   = start && (state inside {IDLE, RUN, ERROR});
  assign asm_byte_en = accept && (state == DATA);

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_en    (asm_byte_en),
    .byte_data  (byte_data),
    .last_byte  (asm_last),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len          <= '0;
      xor_acc      <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            xor_acc      <= '0;
            words_loaded <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            xor_acc  <= xor_acc ^ byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            xor_acc   <= xor_acc ^ byte_data;
            state     <= ({byte_data, len[7:0]} != 16'd0) ? DATA : CHECK;
          end
        end
        DATA: begin
          if (accept) begin
            xor_acc <= xor_acc ^ byte_data;
            // Address is latched with the word so it lines up with the write strobe.
            if (asm_last) begin
              imem_addr    <= words_loaded;
              words_loaded <= words_loaded + 1'b1;
              if (words_loaded == ADDR_WIDTH'(len - 16'd1)) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (accept) state <= (byte_data == xor_acc) ? RUN : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
